axi_burst_master: RTL and testbench
===================================

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 The block SHALL use parameter ADDR_W, default 32, meaning AXI address width.
REQ-002 The block SHALL use parameter DATA_W, default 32, meaning data width (32 or 64); STRB_W = DATA_W/8.
REQ-003 The block SHALL use parameter ID_W, default 4, meaning AXI ID width.
REQ-004 The block SHALL use parameter MST_ID, default 0, meaning constant ARID/AWID value.
REQ-005 The block SHALL use parameter MAX_LEN, default 16, meaning maximum beats per burst (1..256).
REQ-006 The block SHALL have these clock and reset ports: ACLK input 1 (clock, all logic on rising edge); ARESET input 1 (asynchronous, active-high reset).
REQ-007 The block SHALL have these client request ports: req_valid in 1; req_ready out 1; req_we in 1 (1=write); req_addr in ADDR_W (byte address, DATA_W-aligned); req_len in 8 (beats-1).
REQ-008 The block SHALL have these client data ports: wd_valid in 1; wd_ready out 1; wd_data in DATA_W; wd_strb in STRB_W; rd_valid out 1; rd_data out DATA_W; rd_last out 1.
REQ-009 The block SHALL have these client completion ports: done out 1 (one-cycle pulse); err out 1 (valid with done).
REQ-010 The block SHALL have a full AXI4 master port set: AW*, W*, B*, AR*, R* with standard names, widths and directions; AWBURST/ARBURST are 2 bits; AWSIZE/ARSIZE are 3 bits.

Function
REQ-011 The block SHALL use FSM states IDLE, RADDR, RDATA, WADDR, WDATA, WRESP; it SHALL handle one transaction at a time.
REQ-012 req_ready SHALL be 1 only in IDLE; request accepted on req_valid&&req_ready; addr/len/we registered on accept.
REQ-013 On accept, the FSM SHALL go to RADDR if req_we=0 and to WADDR if req_we=1, in the next cycle.
REQ-014 req_len > MAX_LEN-1 SHALL be clamped to MAX_LEN-1 at accept; AXLEN SHALL equal the clamped value.
REQ-015 ARID/AWID=MST_ID; ARSIZE/AWSIZE=log2(STRB_W); ARBURST/AWBURST=INCR; these SHALL be constant.
REQ-016 RADDR: ARVALID=1 and ARADDR held stable until ARREADY; on handshake the FSM SHALL go to RDATA.
REQ-017 RDATA: RREADY=1 (the client always accepts); each R handshake SHALL register RDATA into rd_data and pulse rd_valid one cycle later; rd_last SHALL be registered RLAST.
REQ-018 RDATA SHALL exit on the R handshake with RLAST=1 -> IDLE; done pulses in the same cycle as the final rd_valid.
REQ-019 WADDR: AWVALID=1 until AWREADY; WDATA SHALL be entered after the AW handshake (AW strictly precedes W).
REQ-020 WDATA: WVALID=wd_valid, wd_ready=WREADY, WDATA/WSTRB pass through combinationally from wd_data/wd_strb.
REQ-021 The beat counter SHALL reset to 0 at WDATA entry and increment per W handshake; WLAST=1 iff counter==AWLEN.
REQ-022 The W handshake with WLAST SHALL cause a transition to WRESP; there, BREADY=1; the B handshake SHALL cause a transition to IDLE with done pulsing the next cycle.
REQ-023 err SHALL be the sticky OR of (RRESP!=0) over all beats, or of (BRESP!=0), cleared on accept.
REQ-024 Outside their states, ARVALID, AWVALID, WVALID, RREADY, BREADY and wd_ready SHALL be 0.
REQ-025 The block SHALL ignore R beats without RLAST beyond AXLEN+1: an extra beat SHALL still be forwarded, and the FSM SHALL exit only on RLAST.
REQ-026 An unexpected B or R (wrong state) SHALL NOT be acknowledged, since READY=0.
REQ-027 AXI address SHALL never change while the corresponding VALID=1 and READY=0.

Reset
REQ-028 While ARESET=1, the FSM SHALL be IDLE and all VALID/READY outputs, done, err, rd_valid, rd_last and the counter SHALL be 0; addresses and data registers SHALL be 0.
REQ-029 ARESET asserted mid-burst SHALL immediately drop all VALIDs (asynchronous); no completion is reported; after release, req_ready=1 on the first clock edge.

Verification
REQ-030 Single read, len=0, addr 0x100, ARREADY after 2 cycles, RDATA=0xDEADBEEF RLAST=1 -> one rd_valid, rd_data=0xDEADBEEF, rd_last=1, done=1, err=0.
REQ-031 Read burst len=3, addr 0x200, R with random RVALID gaps -> ARLEN=3, four rd_valid pulses in order, rd_last only on the 4th, then done.
REQ-032 Write burst len=3, wd_valid toggling, WREADY stalls -> AW before W, exactly 4 W beats, WLAST on the 4th only, WSTRB equals wd_strb, done after B.
REQ-033 Write with BRESP=2'b10 -> done=1, err=1; next read with OKAY -> err=0.
REQ-034 req_len=200 with MAX_LEN=16 -> AXLEN=15; beats=16.
REQ-035 ARESET pulse during WDATA beat 2 -> WVALID/AWVALID/BREADY=0 at once, no done; after release, a new read completes normally.

Source files
------------

// File: rtl/axi_burst_master_if.sv
// Bus bundle for axi_burst_master: client request/data/completion signals plus a
// full AXI4 master port set.
//   master modport : the burst master's view (drives AW/W/AR valids, client readies)
//   slave  modport : the opposite view (client + AXI slave side)
interface axi_burst_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // Client request
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  // Client data
  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic [STRB_W-1:0] wd_strb;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  // Client completion
  logic              done;
  logic              err;
  // AXI write address
  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWLOCK;
  logic [3:0]        AWCACHE;
  logic [2:0]        AWPROT;
  logic [3:0]        AWQOS;
  logic              AWVALID;
  logic              AWREADY;
  // AXI write data
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  // AXI write response
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  // AXI read address
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic [3:0]        ARQOS;
  logic              ARVALID;
  logic              ARREADY;
  // AXI read data
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    input  req_valid, req_we, req_addr, req_len, wd_valid, wd_data, wd_strb,
    output req_ready, wd_ready, rd_valid, rd_data, rd_last, done, err,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, wd_valid, wd_data, wd_strb,
    input  req_ready, wd_ready, rd_valid, rd_data, rd_last, done, err,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT, AWQOS, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master. A client request (read or write, up to MAX_LEN
// beats) becomes one INCR burst; read beats are forwarded registered to the client, write
// beats pass straight through from the client to W. done pulses once per completed burst,
// err carries the sticky OR of non-OKAY responses for that burst.
//   ACLK   : clock, rising edge
//   ARESET : asynchronous active-high reset
//   bus    : axi_burst_master_if.master (client request/data/completion + AXI4 master)
module axi_burst_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned MST_ID  = 0,
  parameter int unsigned MAX_LEN = 16
) (
  input logic                ACLK,
  input logic                ARESET,
  axi_burst_master_if.master bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [7:0]  LenMax = 8'(MAX_LEN - 1);
  localparam logic [2:0]  AxSize = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWaddr, StWdata, StWresp} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len, r_cnt;
  logic              r_err, r_done, r_rd_valid, r_rd_last;
  logic [DATA_W-1:0] r_rd_data;

  logic w_req_ready, w_arvalid, w_rready, w_awvalid, w_wvalid, w_wd_ready, w_bready;
  logic w_req_hs, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_wlast;
  logic w_unused;

  assign w_wlast = (r_cnt == r_len);

  always_comb begin
    w_state_d   = r_state;
    w_req_ready = 1'b0;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    w_awvalid   = 1'b0;
    w_wvalid    = 1'b0;
    w_wd_ready  = 1'b0;
    w_bready    = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_state_d = bus.req_we ? StWaddr : StRaddr;
      end
      StRaddr: begin
        w_arvalid = 1'b1;
        if (bus.ARREADY) w_state_d = StRdata;
      end
      StRdata: begin
        w_rready = 1'b1;
        // Exit only on RLAST, however many beats the slave actually returns.
        if (bus.RVALID && bus.RLAST) w_state_d = StIdle;
      end
      StWaddr: begin
        w_awvalid = 1'b1;
        if (bus.AWREADY) w_state_d = StWdata;
      end
      StWdata: begin
        w_wvalid   = bus.wd_valid;
        w_wd_ready = bus.WREADY;
        if (bus.wd_valid && bus.WREADY && w_wlast) w_state_d = StWresp;
      end
      StWresp: begin
        w_bready = 1'b1;
        if (bus.BVALID) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Handshakes use the ungated strobes; under reset the registers are held anyway.
  assign w_req_hs = w_req_ready & bus.req_valid;
  assign w_ar_hs  = w_arvalid & bus.ARREADY;
  assign w_r_hs   = w_rready & bus.RVALID;
  assign w_aw_hs  = w_awvalid & bus.AWREADY;
  assign w_w_hs   = w_wvalid & bus.WREADY;
  assign w_b_hs   = w_bready & bus.BVALID;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_r_hs;
      r_rd_last  <= w_r_hs & bus.RLAST;
      // Read completion lines up with the final rd_valid; write completion follows B.
      r_done     <= (w_r_hs & bus.RLAST) | w_b_hs;
      if (w_r_hs) r_rd_data <= bus.RDATA;
      if (w_req_hs) begin
        r_addr <= bus.req_addr;
        r_len  <= (bus.req_len > LenMax) ? LenMax : bus.req_len;
        r_err  <= 1'b0;
      end else if (w_r_hs) begin
        r_err <= r_err | (bus.RRESP != 2'b00);
      end else if (w_b_hs) begin
        r_err <= r_err | (bus.BRESP != 2'b00);
      end
      if (w_aw_hs)     r_cnt <= '0;
      else if (w_w_hs) r_cnt <= r_cnt + 8'd1;
    end
  end

  // Strobes are also gated by ARESET so they fall the instant reset rises.
  assign bus.req_ready = w_req_ready & ~ARESET;
  assign bus.ARVALID   = w_arvalid & ~ARESET;
  assign bus.RREADY    = w_rready & ~ARESET;
  assign bus.AWVALID   = w_awvalid & ~ARESET;
  assign bus.WVALID    = w_wvalid & ~ARESET;
  assign bus.wd_ready  = w_wd_ready & ~ARESET;
  assign bus.BREADY    = w_bready & ~ARESET;

  assign bus.ARID    = ID_W'(MST_ID);
  assign bus.ARADDR  = r_addr;
  assign bus.ARLEN   = r_len;
  assign bus.ARSIZE  = AxSize;
  assign bus.ARBURST = 2'b01;
  assign bus.ARLOCK  = 1'b0;
  assign bus.ARCACHE = 4'b0000;
  assign bus.ARPROT  = 3'b000;
  assign bus.ARQOS   = 4'b0000;

  assign bus.AWID    = ID_W'(MST_ID);
  assign bus.AWADDR  = r_addr;
  assign bus.AWLEN   = r_len;
  assign bus.AWSIZE  = AxSize;
  assign bus.AWBURST = 2'b01;
  assign bus.AWLOCK  = 1'b0;
  assign bus.AWCACHE = 4'b0000;
  assign bus.AWPROT  = 3'b000;
  assign bus.AWQOS   = 4'b0000;

  assign bus.WDATA = bus.wd_data;
  assign bus.WSTRB = bus.wd_strb;
  assign bus.WLAST = w_wlast;

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_last  = r_rd_last;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

  // Response IDs are not needed with a single fixed ID and one burst in flight.
  assign w_unused = ^{bus.BID, bus.RID};
endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int SelReqReady = 0, SelArvalid = 1, SelRready = 2;
  localparam int SelAwvalid = 3, SelWdReady = 4, SelBready = 5;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic last; } rd_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;

  logic ACLK = 1'b0;
  logic ARESET;
  int   checks = 0;
  int   errors = 0;

  ax_t  exp_ar[$];
  ax_t  exp_aw[$];
  rd_t  exp_rd[$];
  w_t   exp_w[$];
  logic exp_done[$];

  logic [3:0] strb_tab [4] = '{4'hF, 4'h3, 4'hC, 4'h9};
  int         gap_tab  [4] = '{0, 2, 1, 3};

  // Monitor history
  logic        aw_seen = 1'b0, ar_stall = 1'b0, aw_stall = 1'b0, r_hs_q = 1'b0, b_hs_q = 1'b0;
  logic [31:0] ar_addr_q = '0, aw_addr_q = '0;

  always #5 ACLK = ~ACLK;

  axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  axi_burst_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W),
    .MST_ID (5),
    .MAX_LEN(16)
  ) u_dut (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    errors++;
    $display("FAIL unexpected_%s actual=present required=none", name);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SelReqReady: return bus.req_ready;
      SelArvalid:  return bus.ARVALID;
      SelRready:   return bus.RREADY;
      SelAwvalid:  return bus.AWVALID;
      SelWdReady:  return bus.wd_ready;
      SelBready:   return bus.BREADY;
      default:     return 1'b0;
    endcase
  endfunction

  // Returns at a falling edge where the selected signal is high (or after a bounded wait).
  task automatic wait_sig(input int sel, input string name);
    int n = 0;
    @(negedge ACLK);
    while (!sig(sel) && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    if (!sig(sel)) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s actual=0 required=1", name);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, pops expectations as outputs appear.
  initial begin : monitor
    ax_t  a;
    rd_t  r;
    w_t   w;
    logic e;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        aw_seen = 1'b0; ar_stall = 1'b0; aw_stall = 1'b0; r_hs_q = 1'b0; b_hs_q = 1'b0;
      end else begin
        if (ar_stall && bus.ARVALID) chk("araddr_stable", 64'(bus.ARADDR), 64'(ar_addr_q));
        if (aw_stall && bus.AWVALID) chk("awaddr_stable", 64'(bus.AWADDR), 64'(aw_addr_q));
        if (r_hs_q) chk("rd_valid_after_r", 64'(bus.rd_valid), 64'd1);
        if (b_hs_q) chk("done_after_b", 64'(bus.done), 64'd1);
        ar_stall  = bus.ARVALID && !bus.ARREADY;
        ar_addr_q = bus.ARADDR;
        aw_stall  = bus.AWVALID && !bus.AWREADY;
        aw_addr_q = bus.AWADDR;
        r_hs_q    = bus.RVALID && bus.RREADY;
        b_hs_q    = bus.BVALID && bus.BREADY;

        if (bus.ARVALID && bus.ARREADY) begin
          if (exp_ar.size() == 0) unexp("ar");
          else begin
            a = exp_ar.pop_front();
            chk("araddr", 64'(bus.ARADDR), 64'(a.addr));
            chk("arlen", 64'(bus.ARLEN), 64'(a.len));
            chk("arsize", 64'(bus.ARSIZE), 64'd2);
            chk("arburst", 64'(bus.ARBURST), 64'd1);
            chk("arid", 64'(bus.ARID), 64'd5);
          end
        end
        if (bus.AWVALID && bus.AWREADY) begin
          if (exp_aw.size() == 0) unexp("aw");
          else begin
            a = exp_aw.pop_front();
            chk("awaddr", 64'(bus.AWADDR), 64'(a.addr));
            chk("awlen", 64'(bus.AWLEN), 64'(a.len));
            chk("awsize", 64'(bus.AWSIZE), 64'd2);
            chk("awburst", 64'(bus.AWBURST), 64'd1);
            chk("awid", 64'(bus.AWID), 64'd5);
          end
          aw_seen = 1'b1;
        end
        if (bus.WVALID && bus.WREADY) begin
          chk("aw_before_w", 64'(aw_seen), 64'd1);
          if (exp_w.size() == 0) unexp("w");
          else begin
            w = exp_w.pop_front();
            chk("wdata", 64'(bus.WDATA), 64'(w.data));
            chk("wstrb", 64'(bus.WSTRB), 64'(w.strb));
            chk("wlast", 64'(bus.WLAST), 64'(w.last));
          end
          if (bus.WLAST) aw_seen = 1'b0;
        end
        if (bus.rd_valid) begin
          if (exp_rd.size() == 0) unexp("rd");
          else begin
            r = exp_rd.pop_front();
            chk("rd_data", 64'(bus.rd_data), 64'(r.data));
            chk("rd_last", 64'(bus.rd_last), 64'(r.last));
            if (r.last) chk("done_with_last", 64'(bus.done), 64'd1);
          end
        end
        if (bus.done) begin
          if (exp_done.size() == 0) unexp("done");
          else begin
            e = exp_done.pop_front();
            chk("err", 64'(bus.err), 64'(e));
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] len);
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_valid = 1'b1;
    wait_sig(SelReqReady, "req_ready");
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic serve_ar(input int wait_cycles);
    wait_sig(SelArvalid, "arvalid");
    step();
    repeat (wait_cycles) step();
    bus.ARREADY = 1'b1;
    wait_sig(SelArvalid, "arvalid");
    step();
    bus.ARREADY = 1'b0;
  endtask

  task automatic serve_aw();
    wait_sig(SelAwvalid, "awvalid");
    step();
    bus.AWREADY = 1'b1;
    wait_sig(SelAwvalid, "awvalid");
    step();
    bus.AWREADY = 1'b0;
  endtask

  task automatic serve_read(input int nbeats, input int ar_wait, input logic [1:0] resp,
                            input logic [31:0] base, input bit gaps);
    serve_ar(ar_wait);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) repeat (gap_tab[i % 4]) step();
      bus.RVALID = 1'b1;
      bus.RDATA  = base + 32'(i);
      bus.RLAST  = (i == nbeats - 1);
      bus.RRESP  = resp;
      wait_sig(SelRready, "rready");
      step();
      bus.RVALID = 1'b0;
      bus.RLAST  = 1'b0;
      bus.RRESP  = 2'b00;
    end
  endtask

  task automatic client_wd(input int nbeats, input logic [31:0] base);
    for (int i = 0; i < nbeats; i++) begin
      if (i % 2 == 1) begin
        bus.wd_valid = 1'b0;
        step();
      end
      bus.wd_valid = 1'b1;
      bus.wd_data  = base + 32'(i);
      bus.wd_strb  = strb_tab[i % 4];
      wait_sig(SelWdReady, "wd_ready");
      step();
    end
    bus.wd_valid = 1'b0;
  endtask

  task automatic serve_write(input logic [1:0] bresp);
    int   k    = 0;
    logic seen = 1'b0;
    serve_aw();
    while (!seen && k < 300) begin
      bus.WREADY = (k % 3 != 2);
      @(negedge ACLK);
      if (bus.WVALID && bus.WREADY && bus.WLAST) seen = 1'b1;
      step();
      k++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_wlast actual=0 required=1");
    end
    bus.WREADY = 1'b0;
    step();
    bus.BVALID = 1'b1;
    bus.BRESP  = bresp;
    wait_sig(SelBready, "bready");
    step();
    bus.BVALID = 1'b0;
    bus.BRESP  = 2'b00;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [7:0] exp_len, input int nbeats, input logic [31:0] base,
                         input logic [1:0] resp, input int ar_wait, input bit gaps,
                         input logic exp_err);
    ax_t a;
    rd_t r;
    a.addr = addr;
    a.len  = exp_len;
    exp_ar.push_back(a);
    for (int i = 0; i < nbeats; i++) begin
      r.data = base + 32'(i);
      r.last = (i == nbeats - 1);
      exp_rd.push_back(r);
    end
    exp_done.push_back(exp_err);
    fork
      issue(1'b0, addr, len);
      serve_read(nbeats, ar_wait, resp, base, gaps);
    join
    repeat (3) step();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [7:0] exp_len, input int nbeats, input logic [31:0] base,
                          input logic [1:0] bresp, input logic exp_err);
    ax_t a;
    w_t  w;
    a.addr = addr;
    a.len  = exp_len;
    exp_aw.push_back(a);
    for (int i = 0; i < nbeats; i++) begin
      w.data = base + 32'(i);
      w.strb = strb_tab[i % 4];
      w.last = (i == nbeats - 1);
      exp_w.push_back(w);
    end
    exp_done.push_back(exp_err);
    fork
      issue(1'b1, addr, len);
      client_wd(nbeats, base);
      serve_write(bresp);
    join
    repeat (3) step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    ax_t a;
    w_t  w;
    ARESET        = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wd_valid  = 1'b0; bus.wd_data = '0; bus.wd_strb = '0;
    bus.AWREADY   = 1'b0; bus.WREADY = 1'b0;
    bus.BVALID    = 1'b0; bus.BRESP = 2'b00; bus.BID = '0;
    bus.ARREADY   = 1'b0;
    bus.RVALID    = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 1'b0; bus.RID = '0;

    repeat (3) @(negedge ACLK);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_arvalid", 64'(bus.ARVALID), 64'd0);
    chk("rst_awvalid", 64'(bus.AWVALID), 64'd0);
    chk("rst_wvalid", 64'(bus.WVALID), 64'd0);
    chk("rst_rready", 64'(bus.RREADY), 64'd0);
    chk("rst_bready", 64'(bus.BREADY), 64'd0);
    chk("rst_wd_ready", 64'(bus.wd_ready), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_last", 64'(bus.rd_last), 64'd0);
    chk("rst_araddr", 64'(bus.ARADDR), 64'd0);
    step();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("req_ready_after_rst", 64'(bus.req_ready), 64'd1);
    step();

    // Single read, ARREADY delayed
    do_read(32'h100, 8'd0, 8'd0, 1, 32'hDEADBEEF, 2'b00, 2, 1'b0, 1'b0);
    // Four-beat read with RVALID gaps
    do_read(32'h200, 8'd3, 8'd3, 4, 32'hA000_0000, 2'b00, 0, 1'b1, 1'b0);
    // Four-beat write with wd_valid gaps and WREADY stalls
    do_write(32'h300, 8'd3, 8'd3, 4, 32'hB000_0000, 2'b00, 1'b0);
    // Write answered with SLVERR, then a clean read clears err
    do_write(32'h340, 8'd1, 8'd1, 2, 32'hB100_0000, 2'b10, 1'b1);
    do_read(32'h380, 8'd0, 8'd0, 1, 32'h1234_5678, 2'b00, 1, 1'b0, 1'b0);
    // Over-long request clamps to MAX_LEN beats
    do_read(32'h500, 8'd200, 8'd15, 16, 32'hC500_0000, 2'b00, 0, 1'b0, 1'b0);
    // Read with SLVERR on every beat
    do_read(32'h540, 8'd1, 8'd1, 2, 32'hC540_0000, 2'b10, 0, 1'b1, 1'b1);

    // Stray R and B in idle must not be acknowledged
    bus.RVALID = 1'b1; bus.RLAST = 1'b1; bus.RDATA = 32'h5555_5555;
    bus.BVALID = 1'b1;
    @(negedge ACLK);
    chk("rready_idle", 64'(bus.RREADY), 64'd0);
    chk("bready_idle", 64'(bus.BREADY), 64'd0);
    step();
    bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.BVALID = 1'b0;
    repeat (2) step();

    // Reset during the third write beat
    a.addr = 32'h400;
    a.len  = 8'd3;
    exp_aw.push_back(a);
    for (int i = 0; i < 2; i++) begin
      w.data = 32'hD000_0000 + 32'(i);
      w.strb = 4'hF;
      w.last = 1'b0;
      exp_w.push_back(w);
    end
    fork
      issue(1'b1, 32'h400, 8'd3);
      serve_aw();
    join
    bus.WREADY  = 1'b1;
    bus.wd_strb = 4'hF;
    for (int i = 0; i < 2; i++) begin
      bus.wd_valid = 1'b1;
      bus.wd_data  = 32'hD000_0000 + 32'(i);
      wait_sig(SelWdReady, "wd_ready");
      step();
    end
    bus.wd_data = 32'hD000_0002;
    #1;
    chk("wvalid_beat2", 64'(bus.WVALID), 64'd1);
    ARESET = 1'b1;
    #1;
    chk("midrst_wvalid", 64'(bus.WVALID), 64'd0);
    chk("midrst_awvalid", 64'(bus.AWVALID), 64'd0);
    chk("midrst_bready", 64'(bus.BREADY), 64'd0);
    chk("midrst_wd_ready", 64'(bus.wd_ready), 64'd0);
    @(negedge ACLK);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_rd_valid", 64'(bus.rd_valid), 64'd0);
    step();
    bus.wd_valid = 1'b0;
    bus.WREADY   = 1'b0;
    ARESET       = 1'b0;
    step();
    chk("req_ready_after_midrst", 64'(bus.req_ready), 64'd1);
    repeat (2) step();

    do_read(32'h600, 8'd0, 8'd0, 1, 32'hCAFE_F00D, 2'b00, 0, 1'b0, 1'b0);

    repeat (5) step();
    chk("left_ar", 64'(exp_ar.size()), 64'd0);
    chk("left_aw", 64'(exp_aw.size()), 64'd0);
    chk("left_w", 64'(exp_w.size()), 64'd0);
    chk("left_rd", 64'(exp_rd.size()), 64'd0);
    chk("left_done", 64'(exp_done.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
